// File: rtl/audio_sram_fetch_pkg.sv
// Shared definitions for the audio SRAM playback path: default sample width,
// SRAM geometry and the fetch FSM state encoding.
package audio_sram_fetch_pkg;

  localparam int unsigned AudDataWidth  = 16;
  localparam int unsigned SramAddrWidth = 18;
  localparam int unsigned SramDataNum   = 262144;

  typedef enum logic {
    StIdle = 1'b0,
    StReq  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/audio_word_fifo.sv
// Synchronous word FIFO with single-word write and a two-word pop that exposes
// the head and the entry behind it.
module audio_word_fifo
  import audio_sram_fetch_pkg::*;
#(
  parameter int unsigned Width = AudDataWidth,
  parameter int unsigned Depth = 8,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             wr_en_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic             pop2_i,
  output logic [Width-1:0] head_o,
  output logic [Width-1:0] head_next_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  rd_ptr_next;
  logic [CntW-1:0]  count_q, count_d;

  assign rd_ptr_next = rd_ptr_q + PtrW'(1);
  assign head_o      = mem_q[rd_ptr_q];
  assign head_next_o = mem_q[rd_ptr_next];
  assign count_o     = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en_i) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop2_i) begin
        rd_ptr_d = rd_ptr_q + PtrW'(2);
      end
      // Write and pop in one cycle net out to -1.
      count_d = count_q + (wr_en_i ? CntW'(1) : CntW'(0)) - (pop2_i ? CntW'(2) : CntW'(0));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i && !clear_i) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/audio_sram_fetch.sv
// Streams L/R sample words from SRAM into a small FIFO and presents one stereo
// pair per LRCK falling edge for the DAC serializer.
module audio_sram_fetch
  import audio_sram_fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = SramAddrWidth,
  parameter int unsigned DATA_WIDTH = AudDataWidth,
  parameter int unsigned DATA_NUM   = SramDataNum,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned FIFO_DEPTH = 8,
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  input  logic                  iENABLE,
  input  logic                  iFLUSH,
  input  logic                  iAUD_LRCK,
  output logic [ADDR_WIDTH-1:0] oSRAM_ADDR,
  output logic                  oSRAM_RD,
  input  logic                  iSRAM_ACK,
  input  logic [DATA_WIDTH-1:0] iSRAM_DATA,
  output logic [DATA_WIDTH-1:0] oLEFT,
  output logic [DATA_WIDTH-1:0] oRIGHT,
  output logic                  oSAMPLE_VALID,
  output logic                  oUNDERRUN,
  output logic [CntW-1:0]       oFIFO_COUNT
);

  localparam logic [ADDR_WIDTH-1:0] FirstAddr = ADDR_WIDTH'(START_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LastAddr  = ADDR_WIDTH'(START_ADDR + DATA_NUM - 1);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic                  flush_pend_q, flush_pend_d;
  logic                  lrck_q;
  logic                  underrun_q, underrun_d;
  logic [DATA_WIDTH-1:0] left_q, left_d;
  logic [DATA_WIDTH-1:0] right_q, right_d;
  logic                  valid_q, valid_d;

  logic [DATA_WIDTH-1:0] fifo_head, fifo_head_next;
  logic [CntW-1:0]       fifo_count;
  logic                  fifo_full;
  logic                  fifo_wr;
  logic                  fifo_pop;
  logic                  frame_edge;
  logic                  flush_req;
  logic                  flush_apply;
  logic                  pop_ok;

  assign frame_edge  = lrck_q & ~iAUD_LRCK;
  assign flush_req   = iFLUSH | flush_pend_q;
  // A flush waits for any outstanding ack; its data is then dropped.
  assign flush_apply = flush_req & ((state_q == StIdle) | iSRAM_ACK);
  assign fifo_wr     = (state_q == StReq) & iSRAM_ACK & ~flush_req;
  assign fifo_full   = (fifo_count == CntW'(FIFO_DEPTH));
  assign pop_ok      = frame_edge & ~iFLUSH & ~flush_apply;
  // Never consume a lone word so L/R stay paired.
  assign fifo_pop    = pop_ok & (fifo_count >= CntW'(2));

  audio_word_fifo #(
    .Width(DATA_WIDTH),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (iCLK),
    .rst_i      (iRST),
    .clear_i    (flush_apply),
    .wr_en_i    (fifo_wr),
    .wr_data_i  (iSRAM_DATA),
    .pop2_i     (fifo_pop),
    .head_o     (fifo_head),
    .head_next_o(fifo_head_next),
    .count_o    (fifo_count)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    req_addr_d   = req_addr_q;
    flush_pend_d = flush_pend_q;
    case (state_q)
      StIdle: begin
        if (flush_req) begin
          flush_pend_d = 1'b0;
        end else if (iENABLE && !fifo_full) begin
          state_d    = StReq;
          req_addr_d = addr_q;
        end
      end
      StReq: begin
        if (iSRAM_ACK) begin
          state_d      = StIdle;
          flush_pend_d = 1'b0;
          if (!flush_req) begin
            addr_d = (addr_q == LastAddr) ? FirstAddr : addr_q + ADDR_WIDTH'(1);
          end
        end else if (iFLUSH) begin
          flush_pend_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (flush_apply) begin
      addr_d = FirstAddr;
    end
  end

  always_comb begin
    left_d     = left_q;
    right_d    = right_q;
    valid_d    = 1'b0;
    underrun_d = underrun_q;
    if (fifo_pop) begin
      left_d  = fifo_head;
      right_d = fifo_head_next;
      valid_d = 1'b1;
    end
    if (pop_ok && (fifo_count < CntW'(2))) begin
      underrun_d = 1'b1;
    end
    if (flush_apply) begin
      underrun_d = 1'b0;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q      <= StIdle;
      addr_q       <= FirstAddr;
      req_addr_q   <= '0;
      flush_pend_q <= 1'b0;
      lrck_q       <= 1'b0;
      underrun_q   <= 1'b0;
      left_q       <= '0;
      right_q      <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      req_addr_q   <= req_addr_d;
      flush_pend_q <= flush_pend_d;
      lrck_q       <= iAUD_LRCK;
      underrun_q   <= underrun_d;
      left_q       <= left_d;
      right_q      <= right_d;
      valid_q      <= valid_d;
    end
  end

  assign oSRAM_ADDR    = req_addr_q;
  assign oSRAM_RD      = (state_q == StReq);
  assign oLEFT         = left_q;
  assign oRIGHT        = right_q;
  assign oSAMPLE_VALID = valid_q;
  assign oUNDERRUN     = underrun_q;
  assign oFIFO_COUNT   = fifo_count;

endmodule

// File: tb/tb_audio_sram_fetch.sv
// Bench for audio_sram_fetch: queue-level playback model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_audio_sram_fetch;

  localparam int unsigned Depth = 8;
  localparam int unsigned Start = 0;
  localparam int unsigned Num   = 262144;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        flush = 1'b0;
  logic        lrck = 1'b0;
  logic        ack_r = 1'b0;
  logic        ack_force = 1'b0;
  logic        ack;
  logic [15:0] sram_data = '0;
  logic [17:0] addr1;
  logic        rd1;
  logic [15:0] left1, right1;
  logic        valid1, under1;
  logic [3:0]  cnt1;

  logic        en2 = 1'b1;
  logic        ack2 = 1'b0;
  logic [15:0] data2 = '0;
  logic [17:0] addr2;
  logic        rd2;
  logic [15:0] left2, right2;
  logic        valid2, under2;
  logic [3:0]  cnt2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;
  assign ack = ack_r | ack_force;

  audio_sram_fetch u_dut (
    .iCLK(clk), .iRST(rst), .iENABLE(en), .iFLUSH(flush), .iAUD_LRCK(lrck),
    .oSRAM_ADDR(addr1), .oSRAM_RD(rd1), .iSRAM_ACK(ack), .iSRAM_DATA(sram_data),
    .oLEFT(left1), .oRIGHT(right1), .oSAMPLE_VALID(valid1), .oUNDERRUN(under1),
    .oFIFO_COUNT(cnt1)
  );

  audio_sram_fetch #(.DATA_NUM(4), .START_ADDR(10)) u_dut_wrap (
    .iCLK(clk), .iRST(rst), .iENABLE(en2), .iFLUSH(1'b0), .iAUD_LRCK(1'b0),
    .oSRAM_ADDR(addr2), .oSRAM_RD(rd2), .iSRAM_ACK(ack2), .iSRAM_DATA(data2),
    .oLEFT(left2), .oRIGHT(right2), .oSAMPLE_VALID(valid2), .oUNDERRUN(under2),
    .oFIFO_COUNT(cnt2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // SRAM responders: ack on the second cycle of a held read, within a grant limit.
  int ack_limit = 0;
  int acks_done = 0;
  int rd_cyc = 0;
  bit beef = 1'b0;
  int rd2_cyc = 0;

  always @(negedge clk) begin
    ack_r = 1'b0;
    if (rd1 && acks_done < ack_limit) begin
      rd_cyc++;
      if (rd_cyc == 2) begin
        ack_r = 1'b1;
        sram_data = beef ? 16'hBEEF : 16'(addr1 + 18'h100);
        acks_done++;
        rd_cyc = 0;
      end
    end else begin
      rd_cyc = 0;
    end
  end

  always @(negedge clk) begin
    ack2 = 1'b0;
    if (rd2) begin
      rd2_cyc++;
      if (rd2_cyc == 2) begin
        ack2 = 1'b1;
        data2 = 16'(addr2);
        rd2_cyc = 0;
      end
    end else begin
      rd2_cyc = 0;
    end
  end

  // Playback model: FIFO contents as a queue, one outstanding read.
  logic [15:0] m_q[$];
  bit          m_busy = 1'b0;
  logic [17:0] m_raddr = '0;
  int unsigned m_naddr = Start;
  bit          m_fpend = 1'b0;
  bit          m_under = 1'b0;
  logic [15:0] m_left = '0;
  logic [15:0] m_right = '0;
  bit          m_valid = 1'b0;
  bit          m_lrck = 1'b0;

  task automatic model_step();
    int pre;
    bit fedge;
    bit apply;
    if (rst) begin
      m_q.delete();
      m_busy = 0; m_raddr = '0; m_naddr = Start; m_fpend = 0;
      m_under = 0; m_left = '0; m_right = '0; m_valid = 0; m_lrck = 0;
    end else begin
      pre   = m_q.size();
      fedge = m_lrck && !lrck;
      apply = 0;
      m_valid = 0;
      if (m_busy) begin
        if (ack) begin
          m_busy = 0;
          if (flush || m_fpend) apply = 1;
          else begin
            m_q.push_back(sram_data);
            m_naddr = (m_naddr == Start + Num - 1) ? Start : m_naddr + 1;
          end
        end else if (flush) begin
          m_fpend = 1;
        end
      end else if (flush || m_fpend) begin
        apply = 1;
      end else if (en && pre < int'(Depth)) begin
        m_busy  = 1;
        m_raddr = 18'(m_naddr);
      end
      if (fedge && !flush && !apply) begin
        if (pre >= 2) begin
          m_left  = m_q.pop_front();
          m_right = m_q.pop_front();
          m_valid = 1;
        end else begin
          m_under = 1;
        end
      end
      if (apply) begin
        m_q.delete();
        m_naddr = Start; m_under = 0; m_fpend = 0;
      end
      m_lrck = lrck;
    end
  endtask

  logic [17:0] req_log[$];
  logic [17:0] req_log2[$];
  bit rd1_prev = 1'b0;
  bit rd2_prev = 1'b0;
  int vcount = 0;

  always @(posedge clk) begin
    model_step();
    #1;
    chk("rd", 32'(rd1), 32'(m_busy));
    if (m_busy) chk("addr", 32'(addr1), 32'(m_raddr));
    chk("left", 32'(left1), 32'(m_left));
    chk("right", 32'(right1), 32'(m_right));
    chk("valid", 32'(valid1), 32'(m_valid));
    chk("underrun", 32'(under1), 32'(m_under));
    chk("count", 32'(cnt1), 32'(m_q.size()));
    if (rd1 && !rd1_prev && req_log.size() < 16) req_log.push_back(addr1);
    if (rd2 && !rd2_prev && req_log2.size() < 8) req_log2.push_back(addr2);
    rd1_prev = rd1;
    rd2_prev = rd2;
    if (valid1) vcount++;
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic frame_edge();
    lrck = 1'b1;
    tick();
    tick();
    lrck = 1'b0;
    tick();
  endtask

  task automatic wait_size(input int n, input string name);
    int guard = 0;
    while (m_q.size() != n && guard < 300) begin
      tick();
      guard++;
    end
    chk(name, 32'(guard < 300), 32'd1);
  endtask

  initial begin
    int guard;
    int vc0;
    // Reset: everything reads zero.
    tick(); tick();
    chk("rst_left", 32'(left1), 32'h0);
    chk("rst_right", 32'(right1), 32'h0);
    chk("rst_valid", 32'(valid1), 32'h0);
    chk("rst_under", 32'(under1), 32'h0);
    chk("rst_count", 32'(cnt1), 32'h0);
    chk("rst_rd", 32'(rd1), 32'h0);
    chk("rst_addr", 32'(addr1), 32'h0);

    // Fill from address 0 until full.
    rst = 1'b0;
    en = 1'b1;
    ack_limit = acks_done + 1000;
    wait_size(8, "fill_timeout");
    repeat (5) tick();
    chk("full_count", 32'(cnt1), 32'd8);
    chk("full_rd", 32'(rd1), 32'd0);
    chk("model_full", 32'(m_q.size()), 32'd8);
    chk("req_log_len", 32'(req_log.size() >= 8), 32'd1);
    for (int i = 0; i < 8 && i < req_log.size(); i++) chk("req_addr", 32'(req_log[i]), i);

    // One frame edge pops the first pair.
    vc0 = vcount;
    frame_edge();
    chk("pop_left", 32'(left1), 32'h0100);
    chk("pop_right", 32'(right1), 32'h0101);
    chk("pop_count", 32'(cnt1), 32'd6);
    tick(); tick();
    chk("pop_pulses", 32'(vcount - vc0), 32'd1);
    wait_size(8, "refill_timeout");
    chk("refill_count", 32'(cnt1), 32'd8);

    // Underrun: one lone word at a frame edge.
    ack_limit = acks_done;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_idle_count", 32'(cnt1), 32'd0);
    ack_limit = acks_done + 1;
    wait_size(1, "lone_timeout");
    vc0 = vcount;
    frame_edge();
    chk("ur_flag", 32'(under1), 32'd1);
    chk("ur_count", 32'(cnt1), 32'd1);
    chk("ur_left", 32'(left1), 32'h0100);
    chk("ur_right", 32'(right1), 32'h0101);
    chk("ur_pulses", 32'(vcount - vc0), 32'd0);
    ack_limit = acks_done + 1000;
    wait_size(8, "ur_refill_timeout");
    chk("ur_sticky", 32'(under1), 32'd1);

    // Flush during a read at address 5 drops the 0xBEEF ack.
    ack_limit = acks_done;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    ack_limit = acks_done + 5;
    guard = 0;
    while (!(m_busy && m_raddr == 18'd5 && m_q.size() == 5) && guard < 300) begin
      tick();
      guard++;
    end
    chk("req5_timeout", 32'(guard < 300), 32'd1);
    chk("req5_addr", 32'(addr1), 32'd5);
    chk("req5_rd", 32'(rd1), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    beef = 1'b1;
    ack_limit = acks_done + 1;
    guard = 0;
    while (m_busy && guard < 50) begin
      tick();
      guard++;
    end
    beef = 1'b0;
    chk("beef_timeout", 32'(guard < 50), 32'd1);
    chk("beef_count", 32'(cnt1), 32'd0);
    chk("beef_under", 32'(under1), 32'd0);
    guard = 0;
    while (!m_busy && guard < 50) begin
      tick();
      guard++;
    end
    chk("restart_addr", 32'(addr1), 32'd0);
    ack_limit = acks_done + 2;
    wait_size(2, "post_flush_timeout");
    frame_edge();
    chk("post_flush_left", 32'(left1), 32'h0100);
    chk("post_flush_right", 32'(right1), 32'h0101);

    // Reset in the middle of a read, then a stray ack.
    ack_limit = acks_done + 1;
    guard = 0;
    while (!(m_busy && m_q.size() == 1) && guard < 50) begin
      tick();
      guard++;
    end
    chk("pre_rst_timeout", 32'(guard < 50), 32'd1);
    ack_limit = acks_done;
    rst = 1'b1;
    en = 1'b0;
    tick();
    chk("rst_mid_rd", 32'(rd1), 32'd0);
    chk("rst_mid_count", 32'(cnt1), 32'd0);
    rst = 1'b0;
    tick();
    ack_force = 1'b1;
    tick();
    ack_force = 1'b0;
    tick();
    chk("late_ack_count", 32'(cnt1), 32'd0);
    chk("late_ack_rd", 32'(rd1), 32'd0);

    // Wrapping region: 10,11,12,13,10,...
    chk("wrap_log_len", 32'(req_log2.size()), 32'd8);
    for (int i = 0; i < req_log2.size(); i++) chk("wrap_addr", 32'(req_log2[i]), 10 + (i % 4));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end

endmodule

// File: doc/audio_sram_fetch.md
Name: audio_sram_fetch

Overview:
- Upstream feeder for the audio DAC serializer: streams 16-bit stereo samples from SRAM into a small FIFO.
- Presents one left/right sample pair per LRCK frame, registered and stable for the serializer.
- Runs in the codec reference-clock domain. It watches the LRCK produced by the DAC block and advances one stereo pair on each LRCK falling edge.

Parameters:
- ADDR_WIDTH, 18, SRAM word-address width
- DATA_WIDTH, 16, sample/word width
- DATA_NUM, 262144, words in playback region; address wraps after START_ADDR+DATA_NUM-1
- START_ADDR, 0, first word address of playback region
- FIFO_DEPTH, 8, word entries; power of 2, >= 4

Ports:
- iCLK  in  1  reference clock; all logic on rising edge
- iRST  in  1  synchronous, active-high reset
- iENABLE  in  1  allow new SRAM fetches
- iFLUSH  in  1  one-cycle pulse: empty FIFO, rewind address
- iAUD_LRCK  in  1  LRCK from DAC block, synchronous to iCLK
- oSRAM_ADDR  out  ADDR_WIDTH  word address of current read
- oSRAM_RD  out  1  read request, held until ack
- iSRAM_ACK  in  1  one-cycle pulse; iSRAM_DATA valid in same cycle
- iSRAM_DATA  in  DATA_WIDTH  read data
- oLEFT  out  DATA_WIDTH  current left sample
- oRIGHT  out  DATA_WIDTH  current right sample
- oSAMPLE_VALID  out  1  one-cycle pulse when oLEFT/oRIGHT update
- oUNDERRUN  out  1  sticky; set when a frame edge finds fewer than 2 words
- oFIFO_COUNT  out  log2(FIFO_DEPTH)+1  words buffered

Behaviour:
- Reset (iRST=1 at a clock edge) sets:
  - all outputs to 0;
  - address counter to START_ADDR;
  - FIFO empty;
  - FSM to IDLE;
  - LRCK history register to 0.
- Reset mid-request drops oSRAM_RD immediately. An iSRAM_ACK arriving after reset is ignored.
- Fetch FSM, one outstanding read at most:
  - IDLE -> REQ when iENABLE=1, iFLUSH=0 and count < FIFO_DEPTH. The current address is driven on oSRAM_ADDR and oSRAM_RD=1.
  - REQ holds oSRAM_ADDR and oSRAM_RD stable until iSRAM_ACK=1.
  - On ack: the word is written to the FIFO tail, the address increments (wrapping START_ADDR+DATA_NUM-1 -> START_ADDR), oSRAM_RD drops, and the FSM returns to IDLE.
  - Minimum spacing between requests: 1 idle cycle.
- Dropping iENABLE during REQ does not abort the request; it completes normally and no further requests are issued.
- Word order in SRAM is L, R, L, R... starting at START_ADDR.
- Frame edge: lrck_q is the registered iAUD_LRCK. An edge is when lrck_q=1 and iAUD_LRCK=0.
  - If count >= 2 at the edge: pop two words in that cycle. Head goes to oLEFT and head+1 goes to oRIGHT, both on the next clock edge (1-cycle latency). oSAMPLE_VALID pulses in the same cycle the outputs change.
  - If count < 2 at the edge: no pop, oLEFT/oRIGHT hold, oSAMPLE_VALID stays 0, and oUNDERRUN is set. This keeps L/R alignment (a lone word is never consumed).
- Simultaneous write and pop in one cycle: next count = count + 1 - 2. Write and pop never conflict, because the write targets the tail and count >= 2 guarantees head != tail slot.
- FIFO is full at count = FIFO_DEPTH; no request is issued while full.
- iFLUSH:
  - In IDLE: empties the FIFO, sets the address to START_ADDR and clears oUNDERRUN. Outputs hold.
  - In REQ: the pending ack is awaited and its data is discarded, then the flush is applied. A flush request is latched internally until applied.
  - A frame edge coinciding with a flush performs no pop.
- oUNDERRUN clears only on iRST or an applied flush.

Decomposition:
- Shared audio package holds:
  - the DATA_WIDTH default;
  - SRAM geometry constants (ADDR_WIDTH 18, DATA_NUM 262144);
  - the FSM state encoding (IDLE, REQ).
- One natural sub-module: audio_word_fifo. It is a synchronous FIFO with single-word write, a two-word pop, and count output.
- Edge detection, address counter and FSM stay in the top level.

Test Plan:
- Reset then iENABLE=1, SRAM returns addr+0x100 with a 2-cycle ack -> first requests at addr 0,1,2…7 and FIFO fills to count 8. oSRAM_RD stays 0 while full; all outputs were 0 during reset.
- Full FIFO, LRCK falling edge -> one cycle later oLEFT=0x0100, oRIGHT=0x0101 with a single oSAMPLE_VALID pulse. Count goes 8 -> 6, then refills to 8.
- DATA_NUM=4, START_ADDR=10, continuous fetch -> address sequence 10,11,12,13,10,11…
- Hold iSRAM_ACK low so count=1, then an LRCK edge -> no pop, outputs hold, oUNDERRUN=1 and stays 1 after the FIFO refills.
- iFLUSH pulsed during REQ at addr 5, ack data 0xBEEF -> 0xBEEF is not stored, count=0, next request at START_ADDR, oUNDERRUN cleared.
- iRST asserted during REQ with a late ack -> oSRAM_RD=0 next cycle, count stays 0, and the ack has no effect.
